// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: state encoding, fill defaults,
// and the word-counter width.
package mem_arbiter_pkg;

    localparam int FILL_WORDS_DEF = 8;
    localparam int MEM_LAT_DEF    = 4;
    localparam int WCNT_W         = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL_I = 2'd1,
        ST_FILL_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        SRV_I = 1'b0,
        SRV_D = 1'b1
    } served_e;

endpackage

// File: rtl/mem_arbiter_word_counter.sv
// Fill word counter: counts routed data-valid beats, cleared on the last beat.
module arb_word_counter
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              clr_i,
    output logic [WCNT_W-1:0] count_o
);

    logic [WCNT_W-1:0] count_q, count_d;

    // Next count: clear has priority over increment.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + WCNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter between the I-cache and D-cache fill FSMs plus D-cache
// write-through stores. Stores are issued combinationally from IDLE; fills
// own the memory port until FILL_WORDS valid beats have been counted.
//
//   state     | meaning
//   ST_IDLE   | port free; issue store, else arbitrate misses
//   ST_FILL_I | I-cache owns the port, valids routed to I-cache
//   ST_FILL_D | D-cache owns the port, valids routed to D-cache
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int FILL_WORDS = FILL_WORDS_DEF,
    parameter int MEM_LAT    = MEM_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        icache_miss,
    input  logic [15:0] icache_addr,
    input  logic        dcache_miss,
    input  logic [15:0] dcache_addr,
    input  logic        dcache_wr,
    input  logic [15:0] dcache_wr_data,
    input  logic [15:0] mem_data_out,
    input  logic        mem_data_valid,
    output logic [15:0] mem_addr,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_data_in,
    output logic        icache_grant,
    output logic        dcache_grant,
    output logic        icache_data_valid,
    output logic        dcache_data_valid,
    output logic [15:0] fill_data,
    output logic        dcache_wr_ack
);

    // The counter clears on the last beat, so FILL_WORDS must fit its range.
    if (FILL_WORDS < 1 || FILL_WORDS > (1 << WCNT_W) || MEM_LAT < 1) begin : g_param_check
        $error("mem_arbiter: FILL_WORDS must be 1..8 and MEM_LAT >= 1");
    end

    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(FILL_WORDS - 1);

    arb_state_e        state_q, state_d;
    served_e           served_q, served_d;
    logic [WCNT_W-1:0] wcnt;
    logic              routed_valid;
    logic              fill_done;

    // Valids count only while a fill owns the port; IDLE beats are ignored.
    assign routed_valid = (state_q != ST_IDLE) && mem_data_valid;
    assign fill_done    = routed_valid && (wcnt == WCNT_LAST);
    assign fill_data    = mem_data_out;

    arb_word_counter u_wcnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (routed_valid),
        .clr_i   (fill_done),
        .count_o (wcnt)
    );

    // Next-state and memory-port outputs; stores are gated by reset so the
    // port is quiet while rst_n is low.
    always_comb begin
        state_d           = state_q;
        served_d          = served_q;
        mem_addr          = '0;
        mem_enable        = 1'b0;
        mem_wr            = 1'b0;
        mem_data_in       = '0;
        dcache_wr_ack     = 1'b0;
        icache_grant      = 1'b0;
        dcache_grant      = 1'b0;
        icache_data_valid = 1'b0;
        dcache_data_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dcache_wr && rst_n) begin
                    mem_addr      = dcache_addr;
                    mem_enable    = 1'b1;
                    mem_wr        = 1'b1;
                    mem_data_in   = dcache_wr_data;
                    dcache_wr_ack = 1'b1;
                end else if (icache_miss && dcache_miss) begin
                    state_d = (served_q == SRV_I) ? ST_FILL_D : ST_FILL_I;
                end else if (icache_miss) begin
                    state_d = ST_FILL_I;
                end else if (dcache_miss) begin
                    state_d = ST_FILL_D;
                end
            end
            ST_FILL_I: begin
                icache_grant      = 1'b1;
                mem_addr          = icache_addr;
                mem_enable        = icache_miss;
                icache_data_valid = mem_data_valid;
                if (fill_done) begin
                    state_d  = ST_IDLE;
                    served_d = SRV_I;
                end
            end
            ST_FILL_D: begin
                dcache_grant      = 1'b1;
                mem_addr          = dcache_addr;
                mem_enable        = dcache_miss;
                dcache_data_valid = mem_data_valid;
                if (fill_done) begin
                    state_d  = ST_IDLE;
                    served_d = SRV_D;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and last-served registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            served_q <= SRV_I;
        end else begin
            state_q  <= state_d;
            served_q <= served_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency burst memory model.
module tb_mem_arbiter;

    localparam int FILL_WORDS = 8;
    localparam int MEM_LAT    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        icache_miss = 1'b0;
    logic [15:0] icache_addr = '0;
    logic        dcache_miss = 1'b0;
    logic [15:0] dcache_addr = '0;
    logic        dcache_wr = 1'b0;
    logic [15:0] dcache_wr_data = '0;
    logic [15:0] mem_data_out;
    logic        mem_data_valid;
    logic [15:0] mem_addr;
    logic        mem_enable, mem_wr;
    logic [15:0] mem_data_in;
    logic        icache_grant, dcache_grant;
    logic        icache_data_valid, dcache_data_valid;
    logic [15:0] fill_data;
    logic        dcache_wr_ack;

    logic        drv_valid = 1'b0;
    logic        m_valid, m_busy;
    logic [15:0] m_data, m_base;
    int          m_lat, m_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.FILL_WORDS(FILL_WORDS), .MEM_LAT(MEM_LAT)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .icache_miss       (icache_miss),
        .icache_addr       (icache_addr),
        .dcache_miss       (dcache_miss),
        .dcache_addr       (dcache_addr),
        .dcache_wr         (dcache_wr),
        .dcache_wr_data    (dcache_wr_data),
        .mem_data_out      (mem_data_out),
        .mem_data_valid    (mem_data_valid),
        .mem_addr          (mem_addr),
        .mem_enable        (mem_enable),
        .mem_wr            (mem_wr),
        .mem_data_in       (mem_data_in),
        .icache_grant      (icache_grant),
        .dcache_grant      (dcache_grant),
        .icache_data_valid (icache_data_valid),
        .dcache_data_valid (dcache_data_valid),
        .fill_data         (fill_data),
        .dcache_wr_ack     (dcache_wr_ack)
    );

    assign mem_data_valid = m_valid | drv_valid;
    assign mem_data_out   = m_data;

    // Memory: a read strobe starts a burst of FILL_WORDS beats (data = addr+k),
    // first beat MEM_LAT cycles after the address cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_base  <= '0;
            m_lat   <= 0;
            m_cnt   <= 0;
        end else begin
            m_valid <= 1'b0;
            if (!m_busy) begin
                if (mem_enable && !mem_wr) begin
                    m_busy <= 1'b1;
                    m_lat  <= MEM_LAT - 2;
                    m_cnt  <= 0;
                    m_base <= mem_addr;
                end
            end else if (m_lat != 0) begin
                m_lat <= m_lat - 1;
            end else begin
                m_valid <= 1'b1;
                m_data  <= m_base + 16'(m_cnt);
                m_cnt   <= m_cnt + 1;
                if (m_cnt == FILL_WORDS - 1) m_busy <= 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {22'd0, mem_addr, mem_enable, mem_wr, mem_data_in, icache_grant, dcache_grant,
                icache_data_valid, dcache_data_valid, dcache_wr_ack};
    endfunction

    task automatic set_miss(input bit is_i, input logic v);
        if (is_i) icache_miss = v;
        else      dcache_miss = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        icache_miss = 1'b0; dcache_miss = 1'b0; dcache_wr = 1'b0; drv_valid = 1'b0;
        @(negedge clk);
        chk("reset outputs", {all_outs(), fill_data}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Watches one fill: grant ownership, beat count, data, isolation of the
    // other requester, and no store activity; returns first-beat latency.
    task automatic fill_watch(input bit is_i, input logic [15:0] base, input int drop_after,
                              input int stop_after, input string nm, output int lat);
        int cnt = 0, gcyc = 0;
        bit granted = 0, bad_hold = 0, bad_other = 0, bad_wr = 0, bad_data = 0;
        logic g, og, v, ov;
        lat = -1;
        for (int cyc = 0; cyc < 60 && cnt < stop_after; cyc++) begin
            @(negedge clk);
            g  = is_i ? icache_grant : dcache_grant;
            og = is_i ? dcache_grant : icache_grant;
            v  = is_i ? icache_data_valid : dcache_data_valid;
            ov = is_i ? dcache_data_valid : icache_data_valid;
            if (!granted && g) begin
                granted = 1;
                gcyc = cyc;
            end
            if (granted) begin
                if (!g) bad_hold = 1;
                if (og || ov) bad_other = 1;
                if (mem_wr || dcache_wr_ack) bad_wr = 1;
                if (v) begin
                    if (cnt == 0) lat = cyc - gcyc;
                    if (fill_data !== base + 16'(cnt)) bad_data = 1;
                    cnt++;
                    if (cnt == drop_after) set_miss(is_i, 1'b0);
                end
            end
        end
        if (cnt == FILL_WORDS) set_miss(is_i, 1'b0);
        chk({nm, " granted"}, 64'(granted), 64'd1);
        chk({nm, " beat count"}, 64'(cnt), 64'(stop_after));
        chk({nm, " grant held"}, 64'(bad_hold), 64'd0);
        chk({nm, " other side quiet"}, 64'(bad_other), 64'd0);
        chk({nm, " no store during fill"}, 64'(bad_wr), 64'd0);
        chk({nm, " fill data"}, 64'(bad_data), 64'd0);
        if (cnt == FILL_WORDS) begin
            @(negedge clk);
            chk({nm, " idle after"}, {icache_grant, dcache_grant, icache_data_valid, dcache_data_valid}, '0);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        imiss;
        logic        dmiss;
        logic        vin;
        logic        e_en;
        logic        e_wr;
        logic [15:0] e_addr;
        logic [15:0] e_wdata;
        logic        e_ack;
    } vec_t;

    vec_t vecs[6];
    int   lat;
    bit   bad;

    initial begin
        //        wr  addr      wdata     im  dm  vin en  wr  e_addr    e_wdata   ack
        vecs[0] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 16'h0040, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0040, 16'hBEEF, 1'b1};
        vecs[2] = '{1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0001, 1'b1};
        vecs[3] = '{1'b0, 16'h5555, 16'hAAAA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[4] = '{1'b1, 16'h1230, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1230, 16'h0000, 1'b1};
        vecs[5] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};

        do_reset();

        // IDLE combinational behaviour: stores, ignored valids, store-over-miss.
        for (int i = 0; i < 6; i++) begin
            dcache_wr      = vecs[i].wr;
            dcache_addr    = vecs[i].addr;
            dcache_wr_data = vecs[i].wdata;
            icache_addr    = vecs[i].addr;
            icache_miss    = vecs[i].imiss;
            dcache_miss    = vecs[i].dmiss;
            drv_valid      = vecs[i].vin;
            @(negedge clk);
            chk($sformatf("idle vector %0d", i), all_outs(),
                {22'd0, vecs[i].e_addr, vecs[i].e_en, vecs[i].e_wr, vecs[i].e_wdata, 4'b0000, vecs[i].e_ack});
            @(posedge clk); #1;
        end
        dcache_wr = 1'b0; icache_miss = 1'b0; dcache_miss = 1'b0; drv_valid = 1'b0;
        @(posedge clk); #1;

        // I miss alone at 0x1230.
        icache_addr = 16'h1230;
        icache_miss = 1'b1;
        @(negedge clk);
        chk("I miss: no grant in request cycle", 64'(icache_grant), 64'd0);
        fill_watch(1'b1, 16'h1230, 99, FILL_WORDS, "I alone", lat);
        chk("I alone latency", 64'(lat), 64'(MEM_LAT));
        @(posedge clk); #1;

        // Both misses together straight out of reset: D first, then I.
        do_reset();
        icache_addr = 16'h2200;
        dcache_addr = 16'h3300;
        icache_miss = 1'b1;
        dcache_miss = 1'b1;
        fill_watch(1'b0, 16'h3300, 99, FILL_WORDS, "both: D first", lat);
        fill_watch(1'b1, 16'h2200, 99, FILL_WORDS, "both: I second", lat);
        @(posedge clk); #1;

        // Store held off during an I fill, issued in IDLE afterwards.
        icache_addr = 16'h0800;
        icache_miss = 1'b1;
        @(posedge clk); #1;
        dcache_addr    = 16'h0040;
        dcache_wr_data = 16'hBEEF;
        dcache_wr      = 1'b1;
        fill_watch(1'b1, 16'h0800, 99, FILL_WORDS, "store during fill", lat);
        chk("held store issued", {mem_enable, mem_wr, mem_addr, mem_data_in, dcache_wr_ack},
            {1'b1, 1'b1, 16'h0040, 16'hBEEF, 1'b1});
        @(posedge clk); #1;
        dcache_wr = 1'b0;
        @(negedge clk);
        chk("ack is one pulse", 64'(dcache_wr_ack), 64'd0);
        @(posedge clk); #1;

        // Store and I miss together: store acked first, fill follows.
        icache_addr    = 16'h0900;
        dcache_addr    = 16'h0100;
        dcache_wr_data = 16'h1234;
        icache_miss    = 1'b1;
        dcache_wr      = 1'b1;
        @(negedge clk);
        chk("store+miss: store first", {mem_wr, dcache_wr_ack, icache_grant, mem_addr}, {1'b1, 1'b1, 1'b0, 16'h0100});
        @(posedge clk); #1;
        dcache_wr = 1'b0;
        fill_watch(1'b1, 16'h0900, 99, FILL_WORDS, "store+miss: fill", lat);
        @(posedge clk); #1;

        // D miss dropped after the 3rd beat: grant held for all 8.
        dcache_addr = 16'h4400;
        dcache_miss = 1'b1;
        fill_watch(1'b0, 16'h4400, 3, FILL_WORDS, "D drop after 3", lat);
        @(posedge clk); #1;

        // Reset after the 5th beat, then a clean fill.
        icache_addr = 16'h5500;
        icache_miss = 1'b1;
        fill_watch(1'b1, 16'h5500, 99, 5, "I before reset", lat);
        rst_n = 1'b0;
        #1;
        chk("mid-fill reset outputs", {all_outs(), fill_data}, '0);
        @(posedge clk); #1;
        icache_miss = 1'b0;
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (icache_grant || dcache_grant || icache_data_valid || dcache_data_valid || mem_enable) bad = 1;
        end
        chk("quiet after reset", 64'(bad), 64'd0);
        @(posedge clk); #1;
        icache_addr = 16'h6600;
        icache_miss = 1'b1;
        fill_watch(1'b1, 16'h6600, 99, FILL_WORDS, "I after reset", lat);
        chk("I after reset latency", 64'(lat), 64'(MEM_LAT));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
